// File: rtl/muldiv_pkg.sv
// Shared types and default timing for the EXE-stage mul/div sequencer.
// States and default latencies are imported by the controller.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV_BUSY,
        MUL_BUSY,
        DONE
    } muldiv_state_t;

    localparam int DEF_MUL_LAT     = 3;
    localparam int DEF_DIV_TIMEOUT = 40;
    localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// EXE-stage sequencer for the iterative divider and pipelined multiplier.
// Launches one op per instruction, stalls until done, holds HI/LO.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT     = DEF_MUL_LAT,
    parameter int DIV_TIMEOUT = DEF_DIV_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        ex_is_div_i,
    input  logic        ex_is_mult_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op_a_i,
    input  logic [31:0] ex_op_b_i,
    input  logic        ex_flush_i,
    input  logic        pipe_stall_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    input  logic [63:0] mul_result_i,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        signed_o,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             signed_q, signed_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             launch;

    // Flush gates the launch so a dying instruction never starts a unit.
    assign launch = ex_valid_i & (ex_is_div_i | ex_is_mult_i) & ~ex_flush_i;

    // Next-state, counter, operand/result capture and handshake outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        signed_d       = signed_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        div_start_o    = 1'b0;
        div_cancel_o   = 1'b0;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        timeout_o      = 1'b0;

        if (ex_flush_i) begin
            state_d      = IDLE;
            cnt_d        = '0;
            div_cancel_o = (state_q == DIV_BUSY);
        end else begin
            unique case (state_q)
                IDLE: begin
                    stall_o = launch;
                    if (launch) begin
                        op_a_d   = ex_op_a_i;
                        op_b_d   = ex_op_b_i;
                        signed_d = ex_signed_i;
                        if (ex_is_div_i) begin
                            state_d = DIV_BUSY;
                            cnt_d   = '0;
                        end else begin
                            state_d = MUL_BUSY;
                            cnt_d   = MUL_LAST;
                        end
                    end
                end
                DIV_BUSY: begin
                    stall_o     = 1'b1;
                    div_start_o = (cnt_q == '0);
                    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    // A ready on the expiry cycle still delivers its result.
                    if (div_ready_i) begin
                        hi_d    = div_result_i[63:32];
                        lo_d    = div_result_i[31:0];
                        state_d = DONE;
                    end else if (cnt_q == DIV_LAST) begin
                        hi_d         = '0;
                        lo_d         = '0;
                        timeout_o    = 1'b1;
                        div_cancel_o = 1'b1;
                        state_d      = DONE;
                    end
                end
                MUL_BUSY: begin
                    stall_o = 1'b1;
                    if (cnt_q == '0) begin
                        hi_d    = mul_result_i[63:32];
                        lo_d    = mul_result_i[31:0];
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    result_valid_o = 1'b1;
                    if (!pipe_stall_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter, latched operands and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            signed_q <= signed_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign op_a_o   = op_a_q;
    assign op_b_o   = op_b_q;
    assign signed_o = signed_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl.
// Acts as divider/multiplier, checks per cycle.
module tb_muldiv_seq_ctrl;

  localparam int MUL_LAT     = 3;
  localparam int DIV_TIMEOUT = 40;
  localparam int CNT_W       = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_div;
  logic        ex_is_mult, ex_signed;
  logic [31:0] ex_op_a, ex_op_b;
  logic        ex_flush, pipe_stall;
  logic        div_ready;
  logic [63:0] div_result, mul_result;
  logic [31:0] op_a_o, op_b_o;
  logic [31:0] hi_o, lo_o;
  logic        signed_o, div_start_o;
  logic        div_cancel_o, stall_o;
  logic        result_valid_o, timeout_o;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_seq_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_TIMEOUT(DIV_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid_i(ex_valid),
    .ex_is_div_i(ex_is_div),
    .ex_is_mult_i(ex_is_mult),
    .ex_signed_i(ex_signed),
    .ex_op_a_i(ex_op_a),
    .ex_op_b_i(ex_op_b),
    .ex_flush_i(ex_flush),
    .pipe_stall_i(pipe_stall),
    .div_ready_i(div_ready),
    .div_result_i(div_result),
    .mul_result_i(mul_result),
    .op_a_o(op_a_o),
    .op_b_o(op_b_o),
    .signed_o(signed_o),
    .div_start_o(div_start_o),
    .div_cancel_o(div_cancel_o),
    .stall_o(stall_o),
    .result_valid_o(result_valid_o),
    .hi_o(hi_o),
    .lo_o(lo_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  assign flags = {stall_o, div_start_o,
                  div_cancel_o, timeout_o,
                  result_valid_o};

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    ex_is_div  = 1'b0;
    ex_is_mult = 1'b0;
    ex_signed  = 1'b0;
    ex_flush   = 1'b0;
    pipe_stall = 1'b0;
    div_ready  = 1'b0;
    ex_op_a    = $urandom;
    ex_op_b    = $urandom;
    div_result = {$urandom, $urandom};
    mul_result = {$urandom, $urandom};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({flags, hi_o, lo_o, op_a_o,
         op_b_o, signed_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs flags=%b hi=%h lo=%h",
               flags, hi_o, lo_o);
    end
    next_cycle();
  endtask

  task automatic test_idle(input int n);
    for (int c = 0; c < n; c++) begin
      idle_inputs();
      div_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (flags !== 5'b0 || hi_o !== exp_hi ||
          lo_o !== exp_lo) begin
        n_fail++;
        $display("FAIL idle c=%0d flags=%b hi=%h lo=%h",
                 c, flags, hi_o, lo_o);
      end
      next_cycle();
    end
  endtask

  task automatic run_div(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic sgn,
                         input int k,
                         input int hold);
    int          e;
    logic [4:0]  ef;
    logic [31:0] q, r;
    logic [63:0] res;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    res = (k == 0) ? 64'd0 : {r, q};
    e   = (k == 0) ? DIV_TIMEOUT + 1 : k + 1;
    for (int c = 0; c <= e + hold; c++) begin
      idle_inputs();
      ex_valid   = 1'b1;
      ex_is_div  = 1'b1;
      ex_is_mult = $urandom_range(0, 1);
      ex_signed  = (c == 0) ? sgn : ~sgn;
      ex_op_a    = (c == 0) ? a : $urandom;
      ex_op_b    = (c == 0) ? b : $urandom;
      div_ready  = (k != 0 && c == k);
      if (k != 0 && c == k) div_result = {r, q};
      pipe_stall = (c < e) ?
                   1'($urandom_range(0, 1)) :
                   (c < e + hold);
      if (c < e)
        ef = {1'b1, c == 1,
              k == 0 && c == DIV_TIMEOUT,
              k == 0 && c == DIV_TIMEOUT,
              1'b0};
      else
        ef = 5'b00001;
      @(negedge clk);
      n_checks++;
      if (flags !== ef) begin
        n_fail++;
        $display("FAIL div_flags k=%0d c=%0d got %b want %b",
                 k, c, flags, ef);
      end
      if (c >= e) begin
        n_checks++;
        if ({hi_o, lo_o} !== res) begin
          n_fail++;
          $display("FAIL div_result k=%0d c=%0d got %h want %h",
                   k, c, {hi_o, lo_o}, res);
        end
      end
      if (c == e) begin
        n_checks++;
        if (op_a_o !== a || op_b_o !== b ||
            signed_o !== sgn) begin
          n_fail++;
          $display("FAIL div_operands got %h %h %b",
                   op_a_o, op_b_o, signed_o);
        end
      end
      next_cycle();
    end
    {exp_hi, exp_lo} = res;
  endtask

  task automatic run_mul(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic sgn,
                         input int hold);
    int          e;
    logic [4:0]  ef;
    logic [63:0] prod;
    if (sgn)
      prod = 64'(longint'($signed(a)) *
                 longint'($signed(b)));
    else
      prod = {32'd0, a} * {32'd0, b};
    e = MUL_LAT + 1;
    for (int c = 0; c <= e + hold; c++) begin
      idle_inputs();
      ex_valid   = 1'b1;
      ex_is_mult = 1'b1;
      ex_signed  = (c == 0) ? sgn : ~sgn;
      ex_op_a    = (c == 0) ? a : $urandom;
      ex_op_b    = (c == 0) ? b : $urandom;
      div_ready  = $urandom_range(0, 1);
      if (c == MUL_LAT) mul_result = prod;
      pipe_stall = (c < e) ?
                   1'($urandom_range(0, 1)) :
                   (c < e + hold);
      ef = (c < e) ? 5'b10000 : 5'b00001;
      @(negedge clk);
      n_checks++;
      if (flags !== ef) begin
        n_fail++;
        $display("FAIL mul_flags c=%0d got %b want %b",
                 c, flags, ef);
      end
      if (c >= e) begin
        n_checks++;
        if ({hi_o, lo_o} !== prod) begin
          n_fail++;
          $display("FAIL mul_result c=%0d got %h want %h",
                   c, {hi_o, lo_o}, prod);
        end
      end
      if (c == e) begin
        n_checks++;
        if (op_a_o !== a || op_b_o !== b ||
            signed_o !== sgn) begin
          n_fail++;
          $display("FAIL mul_operands got %h %h %b",
                   op_a_o, op_b_o, signed_o);
        end
      end
      next_cycle();
    end
    {exp_hi, exp_lo} = prod;
  endtask

  task automatic run_flush(input int f);
    logic [4:0] ef;
    for (int c = 0; c <= f + 2; c++) begin
      idle_inputs();
      ex_valid  = (c <= f);
      ex_is_div = (c <= f);
      ex_flush  = (c == f);
      div_ready = (c == f + 1);
      if (c < f)       ef = {1'b1, c == 1, 3'b000};
      else if (c == f) ef = 5'b00100;
      else             ef = 5'b00000;
      @(negedge clk);
      n_checks++;
      if (flags !== ef) begin
        n_fail++;
        $display("FAIL flush_flags f=%0d c=%0d got %b want %b",
                 f, c, flags, ef);
      end
      if (c == f + 2) begin
        n_checks++;
        if (hi_o !== exp_hi || lo_o !== exp_lo) begin
          n_fail++;
          $display("FAIL flush_result got %h %h want %h %h",
                   hi_o, lo_o, exp_hi, exp_lo);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mul_reset();
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      ex_valid   = 1'b1;
      ex_is_mult = 1'b1;
      ex_signed  = 1'b1;
      ex_op_a    = 32'h1234_5678;
      ex_op_b    = 32'h0000_0009;
      @(negedge clk);
      n_checks++;
      if (flags !== 5'b10000) begin
        n_fail++;
        $display("FAIL rstmul_flags c=%0d got %b",
                 c, flags);
      end
      next_cycle();
    end
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({flags, hi_o, lo_o, op_a_o,
         op_b_o, signed_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmul_outputs flags=%b hi=%h lo=%h",
               flags, hi_o, lo_o);
    end
    exp_hi = '0;
    exp_lo = '0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    run_mul($urandom, $urandom, 1'b0, 0);
    run_div($urandom,
            32'($urandom_range(1, 500)),
            1'b0, 3, 0);
    run_mul($urandom, $urandom, 1'b1, 1);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_div({1'b0, 31'($urandom)},
                32'($urandom_range(1, 70000)),
                1'($urandom_range(0, 1)),
                $urandom_range(1, DIV_TIMEOUT),
                $urandom_range(0, 3));
      else
        run_mul($urandom, $urandom,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) test_idle(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    run_div(32'd100, 32'd7, 1'b0, 33, 0);
    test_idle(3);
    run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 0);
    run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 5, 5);
    run_flush(10);
    run_flush(1);
    run_div(32'd55, 32'd4, 1'b0, 0, 0);
    run_div(32'd1000, 32'd33, 1'b0,
            DIV_TIMEOUT, 2);
    test_back_to_back();
    test_random(10);
    test_mul_reset();
    run_mul(32'd6, 32'd7, 1'b0, 0);
    test_idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
